jk_counter: RTL

JK_COUNTER -- requirements
Module: jk_counter

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_cell.sv | 45 ++++
 rtl/jk_counter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK counter: operating mode and the {J,K} function encodings.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD,
        JK_LOAD,
        JK_RAW,
        JK_COUNT
    } jk_mode_e;

    // Encodings of the {J,K} input pair.
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One-bit JK flip-flop with asynchronous active-low reset, synchronous load
// (load wins over J/K) and a parameterised reset value.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic INIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ld_i,
    input  logic d_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end else begin
            case ({j_i, k_i})
                HOLD:    q_d = q_q;
                SET:     q_d = 1'b1;
                RESET:   q_d = 1'b0;
                TOGGLE:  q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_counter.sv
// Up/down counter built from per-bit JK cells, with parallel load, raw JK
// mode and a sticky wrap flag. Defining JK_COUNTER_LIMIT_EN adds a LIMIT
// input so the counter runs modulo LIMIT+1.
module jk_counter
    import jk_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             RAW,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             EN,
    input  logic             UP,
`ifdef JK_COUNTER_LIMIT_EN
    input  logic [WIDTH-1:0] LIMIT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    output logic             TC,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    jk_mode_e         mode;
    logic [WIDTH-1:0] lo_ones;
    logic [WIDTH-1:0] lo_zeros;
    logic [WIDTH-1:0] toggle_en;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] top_val;
    logic             jump;
    logic [WIDTH-1:0] jump_val;
    logic             wrap;
    logic             ovf_q;
    logic             ovf_d;

    always_comb begin
        mode = JK_HOLD;
        if (LD) begin
            mode = JK_LOAD;
        end else if (RAW) begin
            mode = JK_RAW;
        end else if (EN) begin
            mode = JK_COUNT;
        end
    end

    // Ripple "all lower bits are 1 / are 0" terms that drive the count toggles.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            if (gi == 0) begin : g_lsb
                assign lo_ones[gi]  = 1'b1;
                assign lo_zeros[gi] = 1'b1;
            end else begin : g_upper
                assign lo_ones[gi]  = lo_ones[gi-1]  &  Q[gi-1];
                assign lo_zeros[gi] = lo_zeros[gi-1] & ~Q[gi-1];
            end
            assign toggle_en[gi] = UP ? lo_ones[gi] : lo_zeros[gi];
        end
    endgenerate

`ifdef JK_COUNTER_LIMIT_EN
    assign top_val = LIMIT;
    // Leaving the modulus range at its edges needs a jump rather than a toggle.
    always_comb begin
        jump     = 1'b0;
        jump_val = '0;
        if (UP && (Q == LIMIT)) begin
            jump     = 1'b1;
            jump_val = '0;
        end else if (!UP && (Q == '0)) begin
            jump     = 1'b1;
            jump_val = LIMIT;
        end
    end
`else
    assign top_val  = ALL_ONES;
    assign jump     = 1'b0;
    assign jump_val = '0;
`endif

    always_comb begin
        j_eff = '0;
        k_eff = '0;
        case (mode)
            JK_RAW: begin
                j_eff = J;
                k_eff = K;
            end
            JK_COUNT: begin
                if (jump) begin
                    j_eff = jump_val;
                    k_eff = ~jump_val;
                end else begin
                    j_eff = toggle_en;
                    k_eff = toggle_en;
                end
            end
            default: begin
                j_eff = '0;
                k_eff = '0;
            end
        endcase
    end

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_cell #(
                .INIT (INIT[gi])
            ) u_cell (
                .clk_i  (CLK),
                .rst_ni (RST_N),
                .ld_i   (LD),
                .d_i    (D[gi]),
                .j_i    (j_eff[gi]),
                .k_i    (k_eff[gi]),
                .q_o    (Q[gi])
            );
        end
    endgenerate

    assign TC = (mode == JK_COUNT) && (UP ? (Q == top_val) : (Q == '0));

    // A natural all-ones rollover also wraps when Q sits above LIMIT.
    assign wrap = (mode == JK_COUNT) &&
                  (UP ? ((Q == top_val) || (Q == ALL_ONES)) : (Q == '0));

    always_comb begin
        ovf_d = ovf_q;
        if (mode == JK_LOAD) begin
            ovf_d = 1'b0;
        end else if (wrap) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
    assign QB  = ~Q;

endmodule
